seg_scan_driver: RTL and testbench

Parametrised, time-multiplexed multi-digit seven-segment display driver. Holds a double-buffered frame of NUM_DIGITS hex nibbles plus decimal points and scans one digit per slot onto shared active-low segment lines and one-hot active-low digit enables. Sits between the register/status logic and the board display pins. It generalises the per-digit BCD decoder to full hex, N digits, refresh timing and anti-ghost blanking.

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_hex_decode.sv | 14 +
 rtl/seg_scan_driver.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan driver.
//   SEG_HEX   - active-low gfedcba patterns for hex digits 0..F
//   SEG_OFF   - all segments dark (active-low)
//   idx_width - width of a digit index counter for a given digit count
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7f;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e
  };

  // A single digit still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low seven-segment pattern.
// Ports:
//   nibble  in  4  hex value 0..F
//   seg_n   out 7  active-low segments, bit0 = a .. bit6 = g
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_HEX[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit seven-segment driver with a
// double-buffered frame, hex decode, per-slot anti-ghost blanking and
// optional leading-zero blanking (define SEG_LZB_EN to enable).
// Ports:
//   clk         in  1              system clock
//   rst_n       in  1              synchronous active-low reset
//   wr_en       in  1              capture wr_digits/wr_dp
//   wr_digits   in  4*NUM_DIGITS   nibble i at [4i+3:4i], digit 0 rightmost
//   wr_dp       in  NUM_DIGITS     decimal points, 1 = lit
//   digit_en    in  NUM_DIGITS     live per-digit enable, 0 = dark
//   seg_n       out 7              segments, active-low
//   dp_n        out 1              decimal point, active-low
//   an_n        out NUM_DIGITS     digit enables, active-low one-hot or all ones
//   frame_done  out 1              one-cycle pulse after each frame boundary
//   pend        out 1              a written frame awaits transfer
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_digits,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done,
  output logic                    pend
);

  localparam int unsigned CntW = $clog2(PRESCALE);
  localparam int unsigned IdxW = idx_width(NUM_DIGITS);

  logic [CntW-1:0]         div_cnt_q, div_cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] active_q, pending_q;
  logic [NUM_DIGITS-1:0]   active_dp_q, pending_dp_q;
  logic                    pend_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q;

  logic       div_wrap, idx_wrap, boundary;
  logic [3:0] cur_nib;
  logic       cur_dp, cur_on, cur_lz, blank_win;
  logic [6:0] dec_seg;

  assign div_wrap = (div_cnt_q == CntW'(PRESCALE - 1));
  assign idx_wrap = (idx_q == IdxW'(NUM_DIGITS - 1));
  assign boundary = div_wrap && idx_wrap;

  always_comb begin
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (div_wrap) idx_d = idx_wrap ? '0 : idx_q + 1'b1;
  end

  // Select the digit currently being scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_on  = 1'b0;
    an_d    = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib = active_q[4*i +: 4];
        cur_dp  = active_dp_q[i];
        cur_on  = digit_en[i];
        an_d[i] = ~digit_en[i];
      end
    end
  end

  seg_hex_decode u_dec (
    .nibble(cur_nib),
    .seg_n (dec_seg)
  );

  // Anti-ghost window at the start of each slot.
  if (BLANK_CYCLES > 0) begin : g_blank
    assign blank_win = (div_cnt_q < CntW'(BLANK_CYCLES));
  end else begin : g_no_blank
    assign blank_win = 1'b0;
  end

`ifdef SEG_LZB_EN
  // Digit i > 0 is a leading zero when it and every higher digit are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    cur_lz   = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      all_zero = all_zero & (active_q[4*i +: 4] == 4'h0);
      if (idx_q == IdxW'(i)) cur_lz = all_zero;
    end
  end
`else
  assign cur_lz = 1'b0;
`endif

  always_comb begin
    seg_d = cur_lz ? SEG_OFF : dec_seg;
    dp_d  = ~cur_dp;
    if (blank_win || !cur_on) begin
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      active_dp_q  <= '0;
      pending_q    <= '0;
      pending_dp_q <= '0;
      pend_q       <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
      if (boundary) begin
        // A write on the boundary bypasses the pending buffer.
        if (wr_en) begin
          active_q    <= wr_digits;
          active_dp_q <= wr_dp;
        end else if (pend_q) begin
          active_q    <= pending_q;
          active_dp_q <= pending_dp_q;
        end
        pend_q <= 1'b0;
      end else if (wr_en) begin
        pending_q    <= wr_digits;
        pending_dp_q <= wr_dp;
        pend_q       <= 1'b1;
      end
    end
  end

  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign an_n       = an_q;
  assign frame_done = frame_done_q;
  assign pend       = pend_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: drives two driver instances (no blanking, 2-cycle
// blanking) with directed then random stimulus and compares every cycle
// against a frame-level reference model built from cycle arithmetic.
module tb_seg_scan_driver;

  localparam int unsigned N  = 4;
  localparam int unsigned P  = 4;
  localparam int unsigned B1 = 2;
  localparam int unsigned FRAME = N * P;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, wr_en;
  logic [4*N-1:0] wr_digits;
  logic [N-1:0]   wr_dp, digit_en;

  logic [6:0]   seg_n0, seg_n1;
  logic         dp_n0, dp_n1, fd0, fd1, pend0, pend1;
  logic [N-1:0] an_n0, an_n1;

  seg_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_digits(wr_digits), .wr_dp(wr_dp),
    .digit_en(digit_en), .seg_n(seg_n0), .dp_n(dp_n0), .an_n(an_n0),
    .frame_done(fd0), .pend(pend0)
  );

  seg_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_digits(wr_digits), .wr_dp(wr_dp),
    .digit_en(digit_en), .seg_n(seg_n1), .dp_n(dp_n1), .an_n(an_n1),
    .frame_done(fd1), .pend(pend1)
  );

  int errs   = 0;
  int checks = 0;

  // Reference model: k counts cycles since reset release.
  int         k;
  logic [3:0] act [N];
  logic       act_dp [N];
  logic [3:0] pnd [N];
  logic       pnd_dp [N];
  logic       m_pend;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (model cycle %0d)", tag, got, exp, k);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Expected visible outputs for the current model state and inputs.
  task automatic expect_out(input logic r, input int unsigned blank,
                            output logic [6:0] seg, output logic dp,
                            output logic [N-1:0] an, output logic fd);
    int unsigned div, idx;
    logic lead;
    div = k % P;
    idx = (k / P) % N;
    if (!r) begin
      seg = 7'h7f; dp = 1'b1; an = '1; fd = 1'b0;
    end else begin
      an = '1;
      if (digit_en[idx]) an[idx] = 1'b0;
      seg = hex7(act[idx]);
      dp  = ~act_dp[idx];
`ifdef SEG_LZB_EN
      lead = (idx > 0);
      for (int j = int'(idx); j < int'(N); j++) if (act[j] != 4'h0) lead = 1'b0;
      if (lead) seg = 7'h7f;
`else
      lead = 1'b0;
`endif
      if (!digit_en[idx] || div < blank) begin
        seg = 7'h7f; dp = 1'b1;
      end
      fd = ((k % FRAME) == FRAME - 1);
    end
  endtask

  task automatic model_step(input logic r);
    if (!r) begin
      k = 0; m_pend = 1'b0;
      for (int i = 0; i < N; i++) begin
        act[i] = 4'h0; act_dp[i] = 1'b0; pnd[i] = 4'h0; pnd_dp[i] = 1'b0;
      end
    end else begin
      if ((k % FRAME) == FRAME - 1) begin
        for (int i = 0; i < N; i++) begin
          if (wr_en) begin
            act[i] = wr_digits[4*i +: 4]; act_dp[i] = wr_dp[i];
          end else if (m_pend) begin
            act[i] = pnd[i]; act_dp[i] = pnd_dp[i];
          end
        end
        m_pend = 1'b0;
      end else if (wr_en) begin
        for (int i = 0; i < N; i++) begin
          pnd[i] = wr_digits[4*i +: 4]; pnd_dp[i] = wr_dp[i];
        end
        m_pend = 1'b1;
      end
      k++;
    end
  endtask

  task automatic cycle(input logic r, input logic w, input logic [4*N-1:0] d,
                       input logic [N-1:0] p, input logic [N-1:0] e);
    logic [6:0] s0, s1;
    logic d0, d1, f0, f1;
    logic [N-1:0] a0, a1;
    rst_n = r; wr_en = w; wr_digits = d; wr_dp = p; digit_en = e;
    @(posedge clk);
    #1;
    expect_out(r, 0, s0, d0, a0, f0);
    expect_out(r, B1, s1, d1, a1, f1);
    check_val("seg0", 32'(seg_n0), 32'(s0));
    check_val("dp0",  32'(dp_n0),  32'(d0));
    check_val("an0",  32'(an_n0),  32'(a0));
    check_val("fd0",  32'(fd0),    32'(f0));
    check_val("seg1", 32'(seg_n1), 32'(s1));
    check_val("dp1",  32'(dp_n1),  32'(d1));
    check_val("an1",  32'(an_n1),  32'(a1));
    check_val("fd1",  32'(fd1),    32'(f1));
    model_step(r);
    check_val("pend0", 32'(pend0), 32'(m_pend));
    check_val("pend1", 32'(pend1), 32'(m_pend));
  endtask

  task automatic idle(input int n, input logic [N-1:0] e);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0, '0, e);
  endtask

  task automatic wait_phase(input int unsigned ph, input logic [N-1:0] e);
    while ((k % FRAME) != ph) cycle(1'b1, 1'b0, '0, '0, e);
  endtask

  initial begin
    k = 0;
    m_pend = 1'b0;
    for (int i = 0; i < N; i++) begin
      act[i] = 4'h0; act_dp[i] = 1'b0; pnd[i] = 4'h0; pnd_dp[i] = 1'b0;
    end
    rst_n = 1'b0; wr_en = 1'b0; wr_digits = '0; wr_dp = '0; digit_en = '1;

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, '0, 4'hF);
    idle(40, 4'hF);

    // Mid-frame write of A510 with the dp on digit 1.
    wait_phase(5, 4'hF);
    cycle(1'b1, 1'b1, 16'hA510, 4'b0010, 4'hF);
    idle(30, 4'hF);

    // Two mid-frame writes, then a write on the boundary cycle.
    wait_phase(3, 4'hF);
    cycle(1'b1, 1'b1, 16'h1234, 4'b0001, 4'hF);
    wait_phase(8, 4'hF);
    cycle(1'b1, 1'b1, 16'h5678, 4'b0100, 4'hF);
    wait_phase(FRAME - 1, 4'hF);
    cycle(1'b1, 1'b1, 16'hBEEF, 4'b1000, 4'hF);
    idle(20, 4'hF);

    // One digit disabled.
    idle(20, 4'b1011);

    // Leading-zero patterns.
    wait_phase(FRAME - 1, 4'hF);
    cycle(1'b1, 1'b1, 16'h0070, 4'b0000, 4'hF);
    idle(20, 4'hF);
    wait_phase(FRAME - 1, 4'hF);
    cycle(1'b1, 1'b1, 16'h0000, 4'b0000, 4'hF);
    idle(20, 4'hF);

    // Reset mid-slot with a frame pending.
    wait_phase(4, 4'hF);
    cycle(1'b1, 1'b1, 16'hC0DE, 4'b0110, 4'hF);
    wait_phase(10, 4'hF);
    cycle(1'b0, 1'b0, '0, '0, 4'hF);
    idle(20, 4'hF);

    for (int i = 0; i < 3000; i++) begin
      logic r, w;
      logic [N-1:0] e;
      r = ($urandom_range(0, 199) != 0);
      w = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      cycle(r, w, (4*N)'($urandom), N'($urandom), e);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
